seq_fxp_mul: RTL and testbench
==============================

Name: seq_fxp_mul

Overview:
- Sequential shift-and-add unsigned fixed-point multiplier; the multiply counterpart of the team's sequential divider, using the same start/busy/valid handshake.
- Each operation takes one WIDTH-bit operand pair and returns the full 2*WIDTH product, a WIDTH-bit fixed-point result and an overflow flag.
- Sits beside the divider in the arithmetic unit and is driven by the same sequencing logic.

Parameters:
- WIDTH, 8: operand and result width in bits.
- FRAC, 4: fractional bits of operands and result (Q(WIDTH-FRAC).FRAC). Must satisfy 0 <= FRAC < WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  multiplicand.
- b_in  in  WIDTH  multiplier.
- busy  out  1  high in every non-IDLE state.
- valid  out  1  one-cycle pulse in DONE.
- product  out  2*WIDTH  full unsigned product.
- result  out  WIDTH  product[WIDTH+FRAC-1:FRAC], truncated.
- ovf  out  1  high when product[2*WIDTH-1:WIDTH+FRAC] is nonzero.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; busy, valid, ovf, product, result and all internal registers go to 0 immediately, with no clock edge needed. This also applies mid-operation: the operation is abandoned and no valid pulse is produced.
- States (3-bit): IDLE, CHECK, TEST, ADD, SHIFT, DONE.
- busy and valid are decoded from the registered state only.
- IDLE: on a rising edge with start=1:
  - a_reg<=a_in, mq<=b_in, acc<=0, carry<=0, cnt<=0; go to CHECK.
  - Otherwise stay in IDLE.
  - product, result and ovf hold their last values.
- CHECK: if a_reg==0 or mq==0, set acc=0 and mq=0, then go to DONE (zero fast path). Else go to TEST.
- TEST: if mq[0]=1 go to ADD, else go to SHIFT.
- ADD: {carry,acc} <= acc + a_reg (WIDTH+1-bit sum, no loss); go to SHIFT.
- SHIFT:
  - {carry,acc,mq} <= {1'b0,carry,acc,mq} >> 1; cnt <= cnt+1.
  - If cnt==WIDTH-1 before the increment, go to DONE; else go to TEST.
  - cnt is clog2(WIDTH)+1 bits wide; no wrap is possible.
- DONE:
  - product <= {acc,mq}; result and ovf are derived from that value and registered on the same edge.
  - valid=1 for this single cycle; busy=1; next state IDLE unconditionally.
  - Outputs are stable from the DONE edge until the next DONE or reset.
- Latency, counted from the cycle start is sampled (cycle 0):
  - Normal path: valid is high in cycle 2 + 2*WIDTH + popcount(b_in).
  - Zero fast path: valid is high in cycle 2.
- start while busy (including DONE): ignored. Operands are not re-sampled, and a_in/b_in may change freely after the accepting edge.
- Back-to-back operation: start sampled in the IDLE cycle directly after DONE is accepted. Minimum issue interval = latency + 1.
- Unused state encodings: go to IDLE next edge, busy=0.

Decomposition:
- Package seq_mul_pkg holds:
  - the state encoding localparams (IDLE=0, CHECK=1, TEST=2, ADD=3, SHIFT=4, DONE=5);
  - the function clog2 used to size cnt.
- One natural sub-module, mul_cu:
  - the pure controller: state register, next-state logic, busy/valid decode;
  - inputs: start, zero_op, mq_lsb, cnt_last;
  - outputs: ld, add_en, shift_en, done_en.
- The top level holds the datapath: a_reg, acc, carry, mq, cnt and the output registers.

Test Plan (WIDTH=8, FRAC=4):
- a=0x18 (1.5), b=0x24 (2.25), start for 1 cycle -> valid only in cycle 20; product=0x0360, result=0x36 (3.375), ovf=0; busy high cycles 1..20.
- a=0x5A, b=0x00 -> zero fast path: valid in cycle 2, product=0x0000, result=0x00, ovf=0.
- a=0xFF, b=0xFF -> valid in cycle 26; product=0xFE01, result=0xE0, ovf=1.
- Start a=0x18,b=0x24, then hold start=1 and change a_in=0x01,b_in=0x01 during busy -> first op still returns 0x0360. Next op accepted in the IDLE cycle after DONE returns 0x0001, valid 19 cycles after that start cycle.
- Pull rst_n low in cycle 7 of a=0xFF,b=0xFF, asynchronously between edges -> busy, valid, product, result, ovf read 0 before the next edge. No valid pulse; the next start after release completes normally.
- Pulse start with rst_n low -> no response: state stays IDLE, busy=0.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential fixed-point multiplier: controller
// state encoding and the width helper used to size the bit counter.
package seq_mul_pkg;

  localparam int STATE_W = 3;

  // Controller states; encodings 6 and 7 are unused and recover to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Ceiling log2, evaluated at elaboration time to size counters.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_cu.sv
// Controller for the shift-and-add multiplier: sequences load, test, add and
// shift steps and decodes busy/valid from the registered state.
module mul_cu
  import seq_mul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_zero_op,
  input  logic i_mq_lsb,
  input  logic i_cnt_last,
  output logic o_busy,
  output logic o_valid,
  output logic o_ld,
  output logic o_add_en,
  output logic o_shift_en,
  output logic o_done_en
);

  state_t r_state;
  state_t w_next;

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and datapath strobes. o_done_en marks the edge that enters
  // DONE, so the result registers update together with the valid pulse.
  always_comb begin
    // NOTE: every output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    w_next     = IDLE;
    o_ld       = 1'b0;
    o_add_en   = 1'b0;
    o_shift_en = 1'b0;
    o_done_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          o_ld   = 1'b1;
          w_next = CHECK;
        end else begin
          w_next = IDLE;
        end
      end
      CHECK: begin
        if (i_zero_op) begin
          o_done_en = 1'b1;
          w_next    = DONE;
        end else begin
          w_next = TEST;
        end
      end
      TEST:  w_next = i_mq_lsb ? ADD : SHIFT;
      ADD: begin
        o_add_en = 1'b1;
        w_next   = SHIFT;
      end
      SHIFT: begin
        o_shift_en = 1'b1;
        if (i_cnt_last) begin
          o_done_en = 1'b1;
          w_next    = DONE;
        end else begin
          w_next = TEST;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake decode from the registered state only.
  always_comb begin
    o_busy  = (r_state == CHECK) || (r_state == TEST) || (r_state == ADD) ||
              (r_state == SHIFT) || (r_state == DONE);
    o_valid = (r_state == DONE);
  end

endmodule

// File: rtl/seq_fxp_mul.sv
// Sequential shift-and-add unsigned fixed-point multiplier. Returns the full
// product, the truncated Q(WIDTH-FRAC).FRAC result and an overflow flag.
module seq_fxp_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               ovf
);

  localparam int CNT_W = clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf;

  logic               w_ld;
  logic               w_add_en;
  logic               w_shift_en;
  logic               w_done_en;
  logic               w_zero_op;
  logic               w_cnt_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_sh;
  logic [WIDTH-1:0]   w_mq_sh;
  logic [2*WIDTH-1:0] w_prod_next;

  mul_cu u_cu (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_zero_op  (w_zero_op),
    .i_mq_lsb   (r_mq[0]),
    .i_cnt_last (w_cnt_last),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_ld       (w_ld),
    .o_add_en   (w_add_en),
    .o_shift_en (w_shift_en),
    .o_done_en  (w_done_en)
  );

  // Datapath combinational terms: add with carry kept, one-bit right shift of
  // {carry,acc,mq}, and the product about to be committed on entry to DONE.
  always_comb begin
    w_zero_op   = (r_a == '0) || (r_mq == '0);
    w_cnt_last  = (r_cnt == CNT_W'(WIDTH - 1));
    w_sum       = {1'b0, r_acc} + {1'b0, r_a};
    w_acc_sh    = {r_carry, r_acc[WIDTH-1:1]};
    w_mq_sh     = {r_acc[0], r_mq[WIDTH-1:1]};
    w_prod_next = w_shift_en ? {w_acc_sh, w_mq_sh} : '0;
  end

  // Operand, accumulator, multiplier/quotient and bit-count registers.
  // NOTE: these are plain registers, not a memory, so all of them are cleared
  // by the async reset and an abandoned operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_ld) begin
      r_a     <= a_in;
      r_mq    <= b_in;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_add_en) begin
      {r_carry, r_acc} <= w_sum;
    end else if (w_shift_en) begin
      r_acc   <= w_acc_sh;
      r_mq    <= w_mq_sh;
      r_carry <= 1'b0;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else if (w_done_en) begin
      // Zero fast path out of CHECK.
      r_acc <= '0;
      r_mq  <= '0;
    end
  end

  // Output registers, updated only when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else if (w_done_en) begin
      r_product <= w_prod_next;
      r_result  <= w_prod_next[WIDTH+FRAC-1:FRAC];
      r_ovf     <= |w_prod_next[2*WIDTH-1:WIDTH+FRAC];
    end
  end

  assign product = r_product;
  assign result  = r_result;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_seq_fxp_mul.sv
// Directed self-checking bench for seq_fxp_mul at WIDTH=8, FRAC=4.
module tb_seq_fxp_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        valid;
  logic [15:0] product;
  logic [7:0]  result;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  seq_fxp_mul #(.WIDTH(8), .FRAC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .valid   (valid),
    .product (product),
    .result  (result),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current (IDLE) cycle, which is cycle 0, and
  // return at the sample point of the valid cycle. With hold=1, start stays
  // high and the operands switch to a2/b2 while busy.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int exp_lat, input logic [15:0] exp_prod,
                       input logic [7:0] exp_res, input logic exp_ovf,
                       input bit hold, input logic [7:0] a2, input logic [7:0] b2);
    int cyc;
    bit got;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    cyc   = 0;
    got   = 1'b0;
    while (!got && cyc < 60) begin
      tick();
      cyc++;
      if (hold) begin
        a_in = a2;
        b_in = b2;
      end else begin
        start = 1'b0;
      end
      if (valid) got = 1'b1;
      else check({tag, " busy before valid"}, 32'(busy), 32'd1);
    end
    check({tag, " valid cycle"}, got ? 32'(cyc) : 32'hFFFF, 32'(exp_lat));
    check({tag, " busy in done"}, 32'(busy), 32'd1);
    check({tag, " product"}, 32'(product), 32'(exp_prod));
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset product", 32'(product), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1.5 * 2.25 = 3.375
    do_op("t1", 8'h18, 8'h24, 20, 16'h0360, 8'h36, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("t1 valid one cycle", 32'(valid), 32'd0);
    check("t1 idle busy", 32'(busy), 32'd0);
    check("t1 product held", 32'(product), 32'h0360);

    // Zero multiplier takes the fast path.
    do_op("t2", 8'h5A, 8'h00, 2, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("t2 idle busy", 32'(busy), 32'd0);

    // Start held through busy with operands changing; then back-to-back issue.
    do_op("t4a", 8'h18, 8'h24, 20, 16'h0360, 8'h36, 1'b0, 1'b1, 8'h01, 8'h01);
    tick();
    check("t4 idle after done", 32'(busy), 32'd0);
    do_op("t4b", 8'h01, 8'h01, 19, 16'h0001, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Largest operands: overflow set.
    do_op("t3", 8'hFF, 8'hFF, 26, 16'hFE01, 8'hE0, 1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    check("t3 product held", 32'(product), 32'hFE01);

    // Asynchronous reset mid-operation, between edges, in cycle 7.
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("t5 busy before reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 busy async", 32'(busy), 32'd0);
    check("t5 valid async", 32'(valid), 32'd0);
    check("t5 product async", 32'(product), 32'd0);
    check("t5 result async", 32'(result), 32'd0);
    check("t5 ovf async", 32'(ovf), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      if (valid) seen = 1'b1;
    end
    check("t5 no valid after abort", 32'(seen), 32'd0);
    check("t5 idle after abort", 32'(busy), 32'd0);
    do_op("t5r", 8'h18, 8'h24, 20, 16'h0360, 8'h36, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Start pulsed while reset is held: no response.
    rst_n = 1'b0;
    a_in  = 8'h18;
    b_in  = 8'h24;
    start = 1'b1;
    repeat (3) begin
      tick();
      check("t6 busy in reset", 32'(busy), 32'd0);
      check("t6 valid in reset", 32'(valid), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("t6 idle after release", 32'(busy), 32'd0);
    check("t6 product cleared", 32'(product), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
